// File: rtl/fc_layer_sequencer_pkg.sv
// Shared definitions for the FC layer sequencer.
//   fc_seq_state_t      : sequencer state encoding
//   DEFAULT_MAC_LATENCY : default datapath depth from sel_ifm to accumulated result
package fc_layer_sequencer_pkg;

    localparam int DEFAULT_MAC_LATENCY = 3;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_RUN,
        S_DRAIN,
        S_BIAS,
        S_CAPTURE,
        S_WRITE
    } fc_seq_state_t;

endpackage

// File: rtl/fc_strobe_delay.sv
// Delays the RUN-phase weight read strobe to build the accumulator strobes.
//   clk, reset  : clock, synchronous active-high reset
//   rd_strobe   : registered weight read enable
//   rd_first    : the current read is address 0
//   acc_enable  : read strobe delayed one cycle (memory read latency)
//   acc_first   : accompanies the acc_enable of address 0
//   acc_last    : the final acc_enable of a pass is in this cycle
//   drain_done  : the last accumulate has travelled MAC_LATENCY further stages
module fc_strobe_delay #(
    parameter int MAC_LATENCY = 3
) (
    input  logic clk,
    input  logic reset,
    input  logic rd_strobe,
    input  logic rd_first,
    output logic acc_enable,
    output logic acc_first,
    output logic acc_last,
    output logic drain_done
);

    // vld_pipe[k] is rd_strobe delayed k+1 cycles
    logic [MAC_LATENCY:0] vld_pipe;
    logic                 first_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            vld_pipe <= '0;
            first_q  <= 1'b0;
        end else begin
            vld_pipe <= {vld_pipe[MAC_LATENCY-1:0], rd_strobe};
            first_q  <= rd_strobe & rd_first;
        end
    end

    assign acc_enable = vld_pipe[0];
    assign acc_first  = first_q;
    assign acc_last   = vld_pipe[0] & ~rd_strobe;
    // Reads are one contiguous burst, so the falling edge at the deepest tap
    // marks the cycle the last product leaves the MAC pipeline.
    assign drain_done = vld_pipe[MAC_LATENCY] & ~vld_pipe[MAC_LATENCY-1];

endmodule

// File: rtl/fc_layer_sequencer.sv
// Control sequencer for one fully-connected layer slice.
// Walks the weight memory / input vector, drives accumulate, bias and capture
// strobes, handshakes with the neighbouring layers and hands weight memory
// ownership to the host only between passes.
//   clk, reset           : clock, synchronous active-high reset
//   start_from_previous  : previous layer's vector is valid (level)
//   end_to_previous      : inputs consumed (pulse)
//   host_req/host_grant  : host weight-write ownership handshake
//   wm_addr_sel          : 1 selects the host address into weight memory
//   wm_address_read/wm_enable_read : weight read port
//   sel_ifm, acc_enable, acc_first : datapath input select / accumulate
//   bias_sel, fc_output_ready      : bias add, result capture (pulses)
//   enable_write_next/next_ready   : write handshake with the next layer
//   output_ready, busy             : status
module fc_layer_sequencer
    import fc_layer_sequencer_pkg::*;
#(
    parameter int IFM_DEPTH       = 100,
    parameter int ADDRESS_SIZE_WM = (IFM_DEPTH > 1) ? $clog2(IFM_DEPTH) : 1,
    parameter int MAC_LATENCY     = DEFAULT_MAC_LATENCY
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       start_from_previous,
    output logic                       end_to_previous,
    input  logic                       host_req,
    output logic                       host_grant,
    output logic                       wm_addr_sel,
    output logic [ADDRESS_SIZE_WM-1:0] wm_address_read,
    output logic                       wm_enable_read,
    output logic [ADDRESS_SIZE_WM-1:0] sel_ifm,
    output logic                       acc_enable,
    output logic                       acc_first,
    output logic                       bias_sel,
    output logic                       fc_output_ready,
    output logic                       enable_write_next,
    input  logic                       next_ready,
    output logic                       output_ready,
    output logic                       busy
);

    localparam logic [ADDRESS_SIZE_WM-1:0] LAST_ADDR = ADDRESS_SIZE_WM'(IFM_DEPTH - 1);

    fc_seq_state_t state, state_n;

    logic [ADDRESS_SIZE_WM-1:0] addr_d;
    logic                       ordy_d;
    logic                       e2p_d;
    logic                       acc_last;
    logic                       drain_done;

    fc_strobe_delay #(
        .MAC_LATENCY (MAC_LATENCY)
    ) u_strobe_delay (
        .clk        (clk),
        .reset      (reset),
        .rd_strobe  (wm_enable_read),
        .rd_first   (wm_address_read == '0),
        .acc_enable (acc_enable),
        .acc_first  (acc_first),
        .acc_last   (acc_last),
        .drain_done (drain_done)
    );

    always_ff @(posedge clk) begin
        if (reset) state <= S_IDLE;
        else       state <= state_n;
    end

    always_comb begin
        state_n = state;
        addr_d  = wm_address_read;
        ordy_d  = output_ready;
        e2p_d   = 1'b0;
        case (state)
            S_IDLE: begin
                // host wins a tie so weights are never rewritten during a pass
                if (host_req)                 state_n = S_LOAD;
                else if (start_from_previous) state_n = S_RUN;
            end
            S_LOAD:    if (!host_req) state_n = S_IDLE;
            S_RUN:     if (wm_address_read == LAST_ADDR) state_n = S_DRAIN;
            S_DRAIN: begin
                e2p_d = acc_last;
                if (drain_done) state_n = S_BIAS;
            end
            S_BIAS:    state_n = S_CAPTURE;
            S_CAPTURE: state_n = S_WRITE;
            S_WRITE: begin
                if (next_ready) begin
                    state_n = S_IDLE;
                    ordy_d  = 1'b1;
                end
            end
            default:   state_n = S_IDLE;
        endcase
        if (state_n == S_RUN) begin
            addr_d = (state == S_RUN) ? wm_address_read + ADDRESS_SIZE_WM'(1) : '0;
            if (state != S_RUN) ordy_d = 1'b0;
        end
    end

    // every output is a flop loaded from the next-state decode
    always_ff @(posedge clk) begin
        if (reset) begin
            wm_address_read   <= '0;
            wm_enable_read    <= 1'b0;
            sel_ifm           <= '0;
            host_grant        <= 1'b0;
            bias_sel          <= 1'b0;
            fc_output_ready   <= 1'b0;
            enable_write_next <= 1'b0;
            output_ready      <= 1'b0;
            end_to_previous   <= 1'b0;
            busy              <= 1'b0;
        end else begin
            wm_address_read   <= addr_d;
            wm_enable_read    <= (state_n == S_RUN);
            sel_ifm           <= wm_address_read;
            host_grant        <= (state_n == S_LOAD);
            bias_sel          <= (state_n == S_BIAS);
            fc_output_ready   <= (state_n == S_CAPTURE);
            enable_write_next <= (state_n == S_WRITE);
            output_ready      <= ordy_d;
            end_to_previous   <= e2p_d;
            busy              <= (state_n != S_IDLE);
        end
    end

    assign wm_addr_sel = host_grant;

endmodule

// File: tb/tb_fc_layer_sequencer.sv
module tb_fc_layer_sequencer;

    localparam int DA = 100;
    localparam int LA = 3;

    logic clk = 1'b0;
    logic reset = 1'b1;
    int   cyc = 0;
    int   errors = 0;
    int   checks = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // DUT A: IFM_DEPTH=100, MAC_LATENCY=3
    logic       a_start = 0, a_host = 0, a_nrdy = 1;
    logic       a_e2p, a_grant, a_asel, a_rd, a_acc, a_first, a_bias, a_fcr, a_ewn, a_ordy, a_busy;
    logic [6:0] a_addr, a_sel;

    fc_layer_sequencer #(.IFM_DEPTH(DA), .MAC_LATENCY(LA)) u_a (
        .clk(clk), .reset(reset), .start_from_previous(a_start), .end_to_previous(a_e2p),
        .host_req(a_host), .host_grant(a_grant), .wm_addr_sel(a_asel),
        .wm_address_read(a_addr), .wm_enable_read(a_rd), .sel_ifm(a_sel),
        .acc_enable(a_acc), .acc_first(a_first), .bias_sel(a_bias),
        .fc_output_ready(a_fcr), .enable_write_next(a_ewn), .next_ready(a_nrdy),
        .output_ready(a_ordy), .busy(a_busy)
    );

    // DUT B: IFM_DEPTH=1, MAC_LATENCY=1
    logic       b_start = 0;
    logic       b_e2p, b_grant, b_asel, b_rd, b_acc, b_first, b_bias, b_fcr, b_ewn, b_ordy, b_busy;
    logic [0:0] b_addr, b_sel;

    fc_layer_sequencer #(.IFM_DEPTH(1), .MAC_LATENCY(1)) u_b (
        .clk(clk), .reset(reset), .start_from_previous(b_start), .end_to_previous(b_e2p),
        .host_req(1'b0), .host_grant(b_grant), .wm_addr_sel(b_asel),
        .wm_address_read(b_addr), .wm_enable_read(b_rd), .sel_ifm(b_sel),
        .acc_enable(b_acc), .acc_first(b_first), .bias_sel(b_bias),
        .fc_output_ready(b_fcr), .enable_write_next(b_ewn), .next_ready(1'b1),
        .output_ready(b_ordy), .busy(b_busy)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    // scoreboard
    typedef struct { int c; int v; bit f; } ev_t;
    ev_t rd_q[$], acc_q[$], ewn_q[$];
    int  e2p_q[$], bias_q[$], fcr_q[$], ordy_q[$];

    // t0 is the IDLE cycle that samples start; ewn_len < 0 means no tail events
    task automatic push_pass(input int t0, input int nrd, input int nacc, input int ewn_len);
        for (int i = 0; i < nrd; i++)  rd_q.push_back('{t0 + 1 + i, i, 1'b0});
        for (int i = 0; i < nacc; i++) acc_q.push_back('{t0 + 2 + i, i, i == 0});
        if (ewn_len > 0) begin
            e2p_q.push_back(t0 + DA + 2);
            bias_q.push_back(t0 + DA + 2 + LA);
            fcr_q.push_back(t0 + DA + 3 + LA);
            ewn_q.push_back('{t0 + DA + 4 + LA, ewn_len, 1'b0});
            ordy_q.push_back(t0 + DA + 4 + LA + ewn_len);
        end
    endtask

    task automatic pulse_ev(input string tag, input logic sig, inout int q[$]);
        if (sig) begin
            if (q.size() == 0) check({tag, "_unexp"}, 1, 0);
            else check(tag, cyc, q.pop_front());
        end
    endtask

    logic ewn_prev = 0, ordy_prev = 0;
    int   ewn_rise = 0;

    always @(negedge clk) begin
        ev_t e;
        if (a_rd) begin
            if (rd_q.size() == 0) check("rd_unexp", 1, 0);
            else begin
                e = rd_q.pop_front();
                check("rd_cyc", cyc, e.c);
                check("rd_addr", a_addr, e.v);
            end
        end
        if (a_acc) begin
            if (acc_q.size() == 0) check("acc_unexp", 1, 0);
            else begin
                e = acc_q.pop_front();
                check("acc_cyc", cyc, e.c);
                check("sel_ifm", a_sel, e.v);
                check("acc_first", a_first, e.f);
            end
        end else if (a_first) check("first_wo_acc", 1, 0);
        pulse_ev("e2p", a_e2p, e2p_q);
        pulse_ev("bias", a_bias, bias_q);
        pulse_ev("fcr", a_fcr, fcr_q);
        if (a_ordy && !ordy_prev) pulse_ev("ordy_rise", 1'b1, ordy_q);
        if (a_ewn && !ewn_prev) ewn_rise = cyc;
        if (!a_ewn && ewn_prev) begin
            if (ewn_q.size() == 0) check("ewn_unexp", 1, 0);
            else begin
                e = ewn_q.pop_front();
                check("ewn_rise", ewn_rise, e.c);
                check("ewn_len", cyc - ewn_rise, e.v);
            end
        end
        ewn_prev  = a_ewn;
        ordy_prev = a_ordy;
    end

    task automatic go(input int n);
        while (cyc < n) @(negedge clk);
    endtask

    initial begin
        int c;
        repeat (3) @(negedge clk);
        check("rst_busy", a_busy, 0);
        check("rst_grant", a_grant, 0);
        check("rst_ordy", a_ordy, 0);
        check("rst_addr", a_addr, 0);
        check("rst_sel", a_sel, 0);
        check("rst_ewn", a_ewn, 0);
        reset = 0;
        @(negedge clk);

        // IFM_DEPTH=1, L=1 on DUT B
        c = cyc; b_start = 1;
        @(negedge clk); b_start = 0;
        check("b_rd1", b_rd, 1); check("b_addr1", b_addr, 0); check("b_acc1", b_acc, 0);
        @(negedge clk);
        check("b_rd2", b_rd, 0); check("b_acc2", b_acc, 1); check("b_first2", b_first, 1);
        check("b_sel2", b_sel, 0);
        @(negedge clk);
        check("b_e2p3", b_e2p, 1); check("b_acc3", b_acc, 0);
        @(negedge clk);
        check("b_bias4", b_bias, 1); check("b_e2p4", b_e2p, 0);
        @(negedge clk);
        check("b_fcr5", b_fcr, 1);
        @(negedge clk);
        check("b_ewn6", b_ewn, 1); check("b_ordy6", b_ordy, 0);
        @(negedge clk);
        check("b_ewn7", b_ewn, 0); check("b_ordy7", b_ordy, 1); check("b_busy7", b_busy, 0);

        // nominal pass, next_ready high
        @(negedge clk);
        c = cyc; a_start = 1; push_pass(c, DA, DA, 1);
        @(negedge clk); a_start = 0;
        go(c + DA + 5 + LA);
        check("p1_ordy", a_ordy, 1);
        check("p1_busy", a_busy, 0);
        check("p1_len", cyc - c, 108);

        // next_ready low for 5 cycles of enable_write_next
        @(negedge clk);
        a_nrdy = 0; c = cyc; a_start = 1; push_pass(c, DA, DA, 6);
        @(negedge clk); a_start = 0;
        check("p2_ordy_clr", a_ordy, 0);
        go(c + DA + 4 + LA + 5);
        a_nrdy = 1;
        go(c + DA + 4 + LA + 7);
        check("p2_ordy", a_ordy, 1);

        // host and start together in IDLE
        @(negedge clk);
        c = cyc; a_host = 1; a_start = 1;
        @(negedge clk);
        check("h_grant", a_grant, 1); check("h_asel", a_asel, 1); check("h_rd", a_rd, 0);
        go(c + 4); a_host = 0; push_pass(c + 5, DA, DA, 1);
        @(negedge clk);
        check("h_release", a_grant, 0);
        @(negedge clk); a_start = 0;
        go(c + 5 + DA + 5 + LA);
        check("h_ordy", a_ordy, 1);

        // host request mid-RUN is held off until the pass completes
        @(negedge clk);
        c = cyc; a_start = 1; push_pass(c, DA, DA, 1);
        @(negedge clk); a_start = 0;
        go(c + 41); a_host = 1;
        go(c + 60); check("m_grant_run", a_grant, 0);
        go(c + DA + 5 + LA); check("m_grant_idle", a_grant, 0);
        @(negedge clk); check("m_grant", a_grant, 1); check("m_asel", a_asel, 1);
        a_host = 0;
        @(negedge clk); check("m_release", a_grant, 0);

        // reset at address 50, then a fresh pass
        @(negedge clk);
        c = cyc; a_start = 1; push_pass(c, 51, 50, -1);
        @(negedge clk); a_start = 0;
        go(c + 51); reset = 1;
        @(negedge clk); reset = 0;
        check("r_rd", a_rd, 0); check("r_acc", a_acc, 0); check("r_addr", a_addr, 0);
        check("r_sel", a_sel, 0); check("r_busy", a_busy, 0); check("r_e2p", a_e2p, 0);
        @(negedge clk);
        c = cyc; a_start = 1; push_pass(c, DA, DA, 1);
        @(negedge clk); a_start = 0;
        go(c + DA + 8 + LA);

        check("q_rd", rd_q.size(), 0);
        check("q_acc", acc_q.size(), 0);
        check("q_e2p", e2p_q.size(), 0);
        check("q_bias", bias_q.size(), 0);
        check("q_fcr", fcr_q.size(), 0);
        check("q_ewn", ewn_q.size(), 0);
        check("q_ordy", ordy_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
